// File: rtl/timer_cpu.sv
// timer_cpu: memory-mapped down-counting timer with prescaler, reload/one-shot mode and level IRQ.
// Define TIMER_CAPTURE_EN to add the synchronised capture_i input and the CAPTURE register.
module timer_cpu #(
  parameter int BaseAddress     = 0,
  parameter int address_width   = 32,
  parameter int data_width      = 32,
  parameter int Address_Wording = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  output logic                     irq_o
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic                     capture_i
`endif
);

  localparam logic [address_width-1:0] ADDR_CTRL   = address_width'(BaseAddress);
  localparam logic [address_width-1:0] ADDR_PSC    = address_width'(BaseAddress + 1 * Address_Wording);
  localparam logic [address_width-1:0] ADDR_LOAD   = address_width'(BaseAddress + 2 * Address_Wording);
  localparam logic [address_width-1:0] ADDR_COUNT  = address_width'(BaseAddress + 3 * Address_Wording);
  localparam logic [address_width-1:0] ADDR_STATUS = address_width'(BaseAddress + 4 * Address_Wording);
  localparam logic [data_width-1:0]    ZERO        = {data_width{1'b0}};
  localparam logic [data_width-1:0]    ONE         = {{(data_width-1){1'b0}}, 1'b1};

  logic [2:0]            ctrl_r;
  logic [15:0]           psc_r;
  logic [15:0]           psc_cnt_r;
  logic [data_width-1:0] load_r;
  logic [data_width-1:0] count_r;
  logic                  exp_r;

  logic                  sel_ctrl_s;
  logic                  sel_psc_s;
  logic                  sel_load_s;
  logic                  sel_count_s;
  logic                  sel_status_s;
  logic                  sel_cap_s;
  logic                  wr_ctrl_s;
  logic                  wr_psc_s;
  logic                  wr_load_s;
  logic                  wr_count_s;
  logic                  wr_status_s;
  logic                  tick_s;
  logic                  exp_set_s;
  logic                  en_nxt_s;
  logic [data_width-1:0] count_nxt_s;
  logic [15:0]           psc_cnt_nxt_s;
  logic [data_width-1:0] rd_data_s;
  logic                  capf_s;
  logic [data_width-1:0] capture_s;

  assign sel_ctrl_s   = (address_i == ADDR_CTRL);
  assign sel_psc_s    = (address_i == ADDR_PSC);
  assign sel_load_s   = (address_i == ADDR_LOAD);
  assign sel_count_s  = (address_i == ADDR_COUNT);
  assign sel_status_s = (address_i == ADDR_STATUS);

  assign wr_ctrl_s   = sel_ctrl_s   & rd_wr_i;
  assign wr_psc_s    = sel_psc_s    & rd_wr_i;
  assign wr_load_s   = sel_load_s   & rd_wr_i;
  assign wr_count_s  = sel_count_s  & rd_wr_i;
  assign wr_status_s = sel_status_s & rd_wr_i;

  // Prescaler only runs while enabled, so a disabled timer can never tick.
  assign tick_s = ctrl_r[0] & (psc_cnt_r == psc_r);

`ifdef TIMER_CAPTURE_EN
  localparam logic [address_width-1:0] ADDR_CAP = address_width'(BaseAddress + 5 * Address_Wording);

  logic                  cap_meta_r;
  logic                  cap_sync_r;
  logic                  cap_prev_r;
  logic                  capf_r;
  logic [data_width-1:0] capture_r;
  logic                  cap_rise_s;

  assign sel_cap_s  = (address_i == ADDR_CAP);
  assign cap_rise_s = cap_sync_r & ~cap_prev_r;
  assign capf_s     = capf_r;
  assign capture_s  = capture_r;

  // Capture path: two-flop synchroniser, edge detect, latch of the pre-write COUNT.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cap_meta_r <= 1'b0;
      cap_sync_r <= 1'b0;
      cap_prev_r <= 1'b0;
      capf_r     <= 1'b0;
      capture_r  <= ZERO;
    end else begin
      cap_meta_r <= capture_i;
      cap_sync_r <= cap_meta_r;
      cap_prev_r <= cap_sync_r;
      capf_r     <= cap_rise_s | (capf_r & ~(wr_status_s & data_i[1]));
      if (cap_rise_s) begin
        capture_r <= count_r;
      end else begin
        capture_r <= capture_r;
      end
    end
  end
`else
  assign sel_cap_s = 1'b0;
  assign capf_s    = 1'b0;
  assign capture_s = ZERO;
`endif

  // Next-state of counter, enable and expiry for the current tick.
  always_comb begin
    count_nxt_s = count_r;
    en_nxt_s    = ctrl_r[0];
    exp_set_s   = 1'b0;
    if (tick_s) begin
      if (count_r != ZERO) begin
        count_nxt_s = count_r - ONE;
      end else begin
        exp_set_s = 1'b1;
        if (ctrl_r[1]) begin
          count_nxt_s = load_r;
        end else begin
          en_nxt_s = 1'b0;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end

    if (wr_ctrl_s || !ctrl_r[0] || tick_s) begin
      psc_cnt_nxt_s = 16'd0;
    end else begin
      psc_cnt_nxt_s = psc_cnt_r + 16'd1;
    end
  end

  // Register file and timer state; bus writes override the timer's own updates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl_r    <= 3'b000;
      psc_r     <= 16'd0;
      psc_cnt_r <= 16'd0;
      load_r    <= ZERO;
      count_r   <= ZERO;
      exp_r     <= 1'b0;
    end else begin
      psc_cnt_r <= psc_cnt_nxt_s;
      exp_r     <= exp_set_s | (exp_r & ~(wr_status_s & data_i[0]));
      if (wr_ctrl_s) begin
        ctrl_r <= data_i[2:0];
      end else begin
        ctrl_r <= {ctrl_r[2:1], en_nxt_s};
      end
      if (wr_psc_s) begin
        psc_r <= data_i[15:0];
      end else begin
        psc_r <= psc_r;
      end
      if (wr_load_s) begin
        load_r <= data_i;
      end else begin
        load_r <= load_r;
      end
      if (wr_count_s) begin
        count_r <= data_i;
      end else begin
        count_r <= count_nxt_s;
      end
    end
  end

  // Read mux: unmatched addresses return zero.
  always_comb begin
    rd_data_s = ZERO;
    if (sel_ctrl_s) begin
      rd_data_s = {{(data_width-3){1'b0}}, ctrl_r};
    end else if (sel_psc_s) begin
      rd_data_s = {{(data_width-16){1'b0}}, psc_r};
    end else if (sel_load_s) begin
      rd_data_s = load_r;
    end else if (sel_count_s) begin
      rd_data_s = count_r;
    end else if (sel_status_s) begin
      rd_data_s = {{(data_width-2){1'b0}}, capf_s, exp_r};
    end else if (sel_cap_s) begin
      rd_data_s = capture_s;
    end else begin
      rd_data_s = ZERO;
    end
  end

  // Registered bus read data and interrupt level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= ZERO;
      irq_o  <= 1'b0;
    end else begin
      data_o <= rd_data_s;
      irq_o  <= exp_r & ctrl_r[2];
    end
  end

endmodule
